allpass_iir_mc: RTL

Parametrised, time-multiplexed second-order all-pass IIR section for the polyphase half-band decimator path. It generalises the single-branch filter to N interleaved channels with a valid handshake, explicit rounding and saturation, per-frame channel resync, synchronous state clear and bypass. One multiply per accepted sample. Result is registered one cycle after acceptance.

---
 rtl/allpass_pkg.sv | 36 +++
 rtl/allpass_mac.sv | 39 +++
 rtl/allpass_iir_mc.sv | 128 ++++++++++++
 3 files changed

// File: rtl/allpass_pkg.sv
// Shared constants and fixed-point helpers for the time-multiplexed all-pass section.
// The helpers work on 64-bit signed words, so every intermediate width must stay <= 64.
package allpass_pkg;

    localparam int DEFAULT_COEF = 613085;

    function automatic int state_w(input int data_w, input int frac_w);
        return data_w + frac_w;
    endfunction

    // Clamp v into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int unsigned      w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (v > max_v) begin
            return max_v;
        end
        if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

    // Add half an LSB of the target precision, then drop sh fraction bits.
    function automatic logic signed [63:0] round_hu(input logic signed [63:0] v,
                                                    input int unsigned      sh);
        if (sh == 0) begin
            return v;
        end
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/allpass_mac.sv
// Combinational datapath of the all-pass section: y = x2 + A*(y2 - x0).
// Produces the saturated full-precision state word and the rounded, saturated output sample.
module allpass_mac
    import allpass_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FRAC_W    = 20,
    parameter int COEF_W    = 21,
    parameter int COEF_FRAC = 20,
    parameter int STATE_W   = DATA_W + FRAC_W
) (
    input  logic signed [STATE_W-1:0] x0_i,
    input  logic signed [STATE_W-1:0] x2_i,
    input  logic signed [STATE_W-1:0] y2_i,
    input  logic signed [COEF_W-1:0]  coef_i,
    output logic signed [STATE_W-1:0] s_o,
    output logic signed [DATA_W-1:0]  y_o
);

    localparam int PROD_W = COEF_W + STATE_W + 1;

    logic signed [STATE_W:0]  d;
    logic signed [PROD_W-1:0] prod;
    logic signed [63:0]       p_rnd;
    logic signed [63:0]       s_sat;
    logic signed [63:0]       y_sat;

    always_comb begin
        d     = {y2_i[STATE_W-1], y2_i} - {x0_i[STATE_W-1], x0_i};
        prod  = PROD_W'(coef_i) * PROD_W'(d);
        p_rnd = round_hu(64'(prod), COEF_FRAC);
        // Saturate the sum so a large step never wraps the stored state.
        s_sat = sat_s(64'(x2_i) + p_rnd, STATE_W);
        y_sat = sat_s(round_hu(s_sat, FRAC_W), DATA_W);
        s_o   = STATE_W'(s_sat);
        y_o   = DATA_W'(y_sat);
    end

endmodule

// File: rtl/allpass_iir_mc.sv
// N-channel interleaved second-order all-pass IIR section with valid handshake,
// per-frame channel resync, synchronous clear, bypass and a single registered output stage.
module allpass_iir_mc
    import allpass_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FRAC_W    = 20,
    parameter int COEF_W    = 21,
    parameter int COEF_FRAC = 20,
    parameter int COEF      = DEFAULT_COEF,
    parameter int NUM_CH    = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_var,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              bypass,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] data_out
);

    localparam int STATE_W = state_w(DATA_W, FRAC_W);
    // Power-of-two depth keeps every channel index in range; unused entries stay at zero.
    localparam int DEPTH   = 1 << CH_W;
    localparam logic signed [COEF_W-1:0] CoefS = COEF_W'(COEF);
    localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

    logic signed [STATE_W-1:0] x1_q [DEPTH];
    logic signed [STATE_W-1:0] x2_q [DEPTH];
    logic signed [STATE_W-1:0] y1_q [DEPTH];
    logic signed [STATE_W-1:0] y2_q [DEPTH];

    logic [CH_W-1:0]   ch_ptr_q, ch_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic                      accept;
    logic [CH_W-1:0]           ch;
    logic signed [STATE_W-1:0] x0;
    logic signed [STATE_W-1:0] mac_s;
    logic signed [DATA_W-1:0]  mac_y;

    assign accept = enable & in_valid & ~clear;
    assign ch     = in_first ? '0 : ch_ptr_q;
    assign x0     = $signed({data_in, {FRAC_W{1'b0}}});

    allpass_mac #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .COEF_W   (COEF_W),
        .COEF_FRAC(COEF_FRAC),
        .STATE_W  (STATE_W)
    ) u_mac (
        .x0_i  (x0),
        .x2_i  (x2_q[ch]),
        .y2_i  (y2_q[ch]),
        .coef_i(CoefS),
        .s_o   (mac_s),
        .y_o   (mac_y)
    );

    always_comb begin
        ch_ptr_d    = ch_ptr_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        data_out_d  = data_out_q;
        if (clear) begin
            ch_ptr_d    = '0;
            out_valid_d = 1'b0;
        end else if (enable) begin
            out_valid_d = in_valid;
            if (in_valid) begin
                ch_ptr_d   = (ch == LastCh) ? '0 : ch + CH_W'(1);
                out_ch_d   = ch;
                data_out_d = bypass ? data_in : mac_y;
            end
        end
    end

    always_ff @(posedge clk_var or posedge reset) begin
        if (reset) begin
            ch_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            data_out_q  <= '0;
        end else begin
            ch_ptr_q    <= ch_ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            data_out_q  <= data_out_d;
        end
    end

    // State keeps updating under bypass so leaving bypass continues the filtered stream.
    always_ff @(posedge clk_var or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else if (accept) begin
            x2_q[ch] <= x1_q[ch];
            x1_q[ch] <= x0;
            y2_q[ch] <= y1_q[ch];
            y1_q[ch] <= mac_s;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign data_out  = data_out_q;

endmodule
